// File: rtl/alu_mc.sv
// alu_mc: multi-cycle picoMIPS ALU with iterative shifts, shift-add multiply and valid/ready handshakes
module alu_mc #(
    parameter int BUS_WIDTH  = 8,
    parameter int FUNC_WIDTH = 4,
    parameter int FLAG_WIDTH = 4,
    parameter int SHAMT_W    = $clog2(BUS_WIDTH)
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BUS_WIDTH-1:0]  a,
    input  logic [BUS_WIDTH-1:0]  b,
    input  logic [FUNC_WIDTH-1:0] func,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUS_WIDTH-1:0]  result,
    output logic [FLAG_WIDTH-1:0] flags
);
    localparam int W  = BUS_WIDTH;
    localparam int CW = SHAMT_W + 1;
    localparam logic [FUNC_WIDTH-1:0] F_RB   = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] F_ADD  = FUNC_WIDTH'(2);
    localparam logic [FUNC_WIDTH-1:0] F_SUB  = FUNC_WIDTH'(3);
    localparam logic [FUNC_WIDTH-1:0] F_AND  = FUNC_WIDTH'(4);
    localparam logic [FUNC_WIDTH-1:0] F_OR   = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] F_XOR  = FUNC_WIDTH'(6);
    localparam logic [FUNC_WIDTH-1:0] F_NOR  = FUNC_WIDTH'(7);
    localparam logic [FUNC_WIDTH-1:0] F_SLL  = FUNC_WIDTH'(8);
    localparam logic [FUNC_WIDTH-1:0] F_SRL  = FUNC_WIDTH'(9);
    localparam logic [FUNC_WIDTH-1:0] F_SRA  = FUNC_WIDTH'(10);
    localparam logic [FUNC_WIDTH-1:0] F_MULL = FUNC_WIDTH'(11);
    localparam logic [FUNC_WIDTH-1:0] F_MULH = FUNC_WIDTH'(12);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state;

    logic [FUNC_WIDTH-1:0] r_func;
    logic [W-1:0]          r_sh;
    logic [W-1:0]          r_mcand;
    logic [2*W-1:0]        r_prod;
    logic [CW-1:0]         r_cnt;

    logic [W:0]         w_add, w_sub, w_sum;
    logic [W-1:0]       w_res, w_sh_next, w_bres;
    logic [2*W-1:0]     w_prod_next;
    logic [SHAMT_W-1:0] w_amt;
    logic               w_c, w_v, w_sh_c, w_bc, w_bv;
    logic               w_is_mul, w_is_shift, w_multi, w_accept, w_last;

    assign in_ready   = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_amt      = b[SHAMT_W-1:0];
    assign w_is_mul   = (func == F_MULL) | (func == F_MULH);
    assign w_is_shift = (func == F_SLL) | (func == F_SRL) | (func == F_SRA);
    assign w_multi    = w_is_mul | (w_is_shift & (w_amt != '0));
    assign w_add      = {1'b0, a} + {1'b0, b};
    assign w_sub      = {1'b0, a} + {1'b0, ~b} + 1'b1;

    // Single-cycle ops; zero-amount shifts and codes 13-15 fall through to result=a, C=V=0
    always_comb begin
        w_res = a;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (func)
            F_RB:  w_res = b;
            F_ADD: begin
                w_res = w_add[W-1:0];
                w_c   = w_add[W];
                w_v   = (a[W-1] == b[W-1]) & (w_add[W-1] != a[W-1]);
            end
            F_SUB: begin
                w_res = w_sub[W-1:0];
                w_c   = w_sub[W];
                w_v   = (a[W-1] != b[W-1]) & (w_sub[W-1] != a[W-1]);
            end
            F_AND: w_res = a & b;
            F_OR:  w_res = a | b;
            F_XOR: w_res = a ^ b;
            F_NOR: w_res = ~(a | b);
            default: w_res = a;
        endcase
    end

    // One iteration step of the shifter and of the shift-add multiplier
    assign w_sh_next   = (r_func == F_SLL) ? {r_sh[W-2:0], 1'b0}
                                           : {(r_func == F_SRA) & r_sh[W-1], r_sh[W-1:1]};
    assign w_sh_c      = (r_func == F_SLL) ? r_sh[W-1] : r_sh[0];
    assign w_sum       = {1'b0, r_prod[2*W-1:W]} + {1'b0, (r_prod[0] ? r_mcand : '0)};
    assign w_prod_next = {w_sum, r_prod[W-1:1]};
    assign w_bres      = (r_func == F_MULL) ? w_prod_next[W-1:0]
                       : (r_func == F_MULH) ? w_prod_next[2*W-1:W] : w_sh_next;
    assign w_bc        = (r_func == F_MULL) | (r_func == F_MULH) ? 1'b0 : w_sh_c;
    assign w_bv        = (r_func == F_MULL) & (|w_prod_next[2*W-1:W]);
    assign w_last      = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state   <= IDLE;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            r_func    <= '0;
            r_sh      <= '0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
        end else if (r_state == BUSY) begin
            r_sh   <= w_sh_next;
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt - 1'b1;
            if (w_last) begin
                result    <= w_bres;
                flags     <= {w_bc, w_bv, w_bres[W-1], ~|w_bres};
                out_valid <= 1'b1;
                r_state   <= DONE;
            end
        end else if (w_accept) begin
            r_func  <= func;
            r_sh    <= a;
            r_mcand <= a;
            r_prod  <= {{W{1'b0}}, b};
            r_cnt   <= w_is_mul ? CW'(W) : {1'b0, w_amt};
            if (w_multi) begin
                out_valid <= 1'b0;
                r_state   <= BUSY;
            end else begin
                result    <= w_res;
                flags     <= {w_c, w_v, w_res[W-1], ~|w_res};
                out_valid <= 1'b1;
                r_state   <= DONE;
            end
        end else if ((r_state == DONE) & out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
        end
    end
endmodule
